// File: rtl/data_cache.sv
// Direct-mapped, 8-line x 1-word write-through data cache without write-allocate.
// Load hits complete combinationally; misses and stores go through a single-word memory port.
module data_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
  output logic [1:0]  dbg_state
);

  // Memory handshake: mem_req is held with stable mem_addr/mem_we/mem_wdata
  // until a single-cycle mem_ready pulse completes the transfer.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  valid_q, valid_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] fill_q, fill_d;

  logic [26:0] tag_mem [8];
  logic [31:0] data_mem [8];

  logic        data_we;
  logic        tag_we;
  logic [31:0] arr_data_d;

  logic [2:0]  req_idx;
  logic [26:0] req_tag;
  logic        req_hit;
  logic [2:0]  line_idx;
  logic [26:0] line_tag;
  logic        unused_addr;

  assign req_idx     = addr[4:2];
  assign req_tag     = addr[31:5];
  assign req_hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign line_idx    = addr_q[2:0];
  assign line_tag    = addr_q[29:3];
  assign unused_addr = ^addr[1:0];

  assign mem_addr   = {addr_q, 2'b00};
  assign mem_wdata  = wdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fill_d     = fill_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    arr_data_d = mem_rdata;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    rdata      = fill_q;

    case (state_q)
      IDLE: begin
        rdata = data_mem[req_idx];
        // Flush wins; the held request is re-evaluated next cycle against the empty cache.
        if (flush) begin
          valid_d = 8'h00;
          stall   = 1'b1;
        end else if (req_valid) begin
          if (req_we) begin
            stall   = 1'b1;
            addr_d  = addr[31:2];
            wdata_d = wdata;
            state_d = WR_THRU;
          end else if (req_hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
          end else begin
            stall   = 1'b1;
            addr_d  = addr[31:2];
            state_d = RD_MISS;
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
          end
        end
      end
      RD_MISS: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready) begin
          data_we           = 1'b1;
          tag_we            = 1'b1;
          valid_d[line_idx] = 1'b1;
          fill_d            = mem_rdata;
          state_d           = RESP;
        end
      end
      WR_THRU: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        stall      = 1'b1;
        arr_data_d = wdata_q;
        if (mem_ready) begin
          // No write-allocate: only a resident line picks up the store.
          data_we = valid_q[line_idx] && (tag_mem[line_idx] == line_tag);
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= 8'h00;
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
      addr_q     <= 30'h0;
      wdata_q    <= 32'h0;
      fill_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fill_q     <= fill_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[line_idx] <= arr_data_d;
    if (tag_we)  tag_mem[line_idx]  <= line_tag;
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a driver issues loads/stores, a memory model answers
// after a fixed latency, and a monitor checks each retiring load against an expected queue.
module tb_data_cache;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  bit          mon_en = 1'b1;

  logic [31:0] mem_arr [64];
  bit          mem_hold = 1'b0;
  logic        mem_ready_a = 1'b0;
  logic        mem_pulse = 1'b0;
  int          mem_cnt = 0;
  logic        last_we;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;

  data_cache dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .addr       (addr),
    .wdata      (wdata),
    .flush      (flush),
    .rdata      (rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory model: answers three cycles after mem_req rises
  assign mem_ready = mem_ready_a | mem_pulse;
  assign mem_rdata = mem_arr[mem_addr[7:2]];

  always @(posedge clk) begin
    #1;
    if (mem_req && !mem_hold) begin
      mem_cnt++;
      if (mem_cnt == 3) begin
        mem_ready_a = 1'b1;
        mem_cnt     = 0;
        last_we     = mem_we;
        last_addr   = mem_addr;
        last_wdata  = mem_wdata;
        if (mem_we) mem_arr[mem_addr[7:2]] = mem_wdata;
      end else begin
        mem_ready_a = 1'b0;
      end
    end else begin
      mem_ready_a = 1'b0;
      mem_cnt     = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a load retires on any cycle it is presented with stall low
  always @(negedge clk) begin
    if (mon_en && req_valid && !req_we && !flush && !stall && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL load_rdata: got %h with no expected entry", rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL load_rdata: got %h expected %h addr %h", rdata, e, addr);
        end
      end
    end
  end

  // Driver tasks: entered and left just after a rising edge
  task automatic wait_release(input string name, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: stall still %b after %0d cycles, required 0", name, stall, stalls);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input bit with_flush,
                         output int stalls);
    req_valid = 1'b1;
    req_we    = 1'b0;
    addr      = a;
    flush     = with_flush;
    exp_q.push_back(exp);
    if (with_flush) begin
      @(negedge clk);
      check("flush_stall", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    wait_release("load", stalls);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    req_valid = 1'b1;
    req_we    = 1'b1;
    addr      = a;
    wdata     = d;
    wait_release("store", stalls);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_counts(input string name, input logic [15:0] h, input logic [15:0] m);
    check({name, "_hits"},   {16'd0, hit_count},  {16'd0, h});
    check({name, "_misses"}, {16'd0, miss_count}, {16'd0, m});
  endtask

  initial begin
    int st;
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
    mem_arr[16] = 32'hDEAD_BEEF;  // 0x40
    mem_arr[24] = 32'hCAFE_F00D;  // 0x60
    mem_arr[49] = 32'h5555_AAAA;  // 0xC4
    req_valid = 1'b0;
    req_we    = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    flush     = 1'b0;
    rst       = 1'b1;
    #2;
    check("rst_state",   {30'd0, dbg_state}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we",  {31'd0, mem_we},  32'd0);
    check("rst_stall",   {31'd0, stall},   32'd0);
    check_counts("rst", 16'd0, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold load then repeat hit
    do_load(32'h40, 32'hDEAD_BEEF, 1'b0, st);
    check("cold_stall_cycles", st, 32'd4);
    check("cold_mem_we",   {31'd0, last_we}, 32'd0);
    check("cold_mem_addr", last_addr, 32'h40);
    check_counts("cold", 16'd0, 16'd1);
    do_load(32'h40, 32'hDEAD_BEEF, 1'b0, st);
    check("rehit_stall_cycles", st, 32'd0);
    check_counts("rehit", 16'd1, 16'd1);

    // Conflict eviction on index 0
    do_reset();
    do_load(32'h40, 32'hDEAD_BEEF, 1'b0, st);
    check("evict_a_stall", st, 32'd4);
    do_load(32'h60, 32'hCAFE_F00D, 1'b0, st);
    check("evict_b_stall", st, 32'd4);
    do_load(32'h40, 32'hDEAD_BEEF, 1'b0, st);
    check("evict_c_stall", st, 32'd4);
    check_counts("evict", 16'd0, 16'd3);
    do_load(32'h40, 32'hDEAD_BEEF, 1'b0, st);
    check("evict_final_hit_stall", st, 32'd0);
    check_counts("evict_final", 16'd1, 16'd3);

    // Write-through hit, then no-allocate miss
    do_store(32'h40, 32'h1234_5678, st);
    check("wt_stall_cycles", st, 32'd4);
    check("wt_mem_we",    {31'd0, last_we}, 32'd1);
    check("wt_mem_addr",  last_addr, 32'h40);
    check("wt_mem_wdata", last_wdata, 32'h1234_5678);
    check_counts("wt", 16'd1, 16'd3);
    do_load(32'h40, 32'h1234_5678, 1'b0, st);
    check("wt_hit_stall", st, 32'd0);
    check_counts("wt_hit", 16'd2, 16'd3);
    do_store(32'h80, 32'h0BAD_C0DE, st);
    check("na_mem_addr", last_addr, 32'h80);
    do_load(32'h80, 32'h0BAD_C0DE, 1'b0, st);
    check("na_miss_stall", st, 32'd4);
    check_counts("na", 16'd2, 16'd4);

    // Flush together with a load of a resident line
    do_load(32'h40, 32'h1234_5678, 1'b0, st);
    check("pre_flush_stall", st, 32'd4);
    check_counts("pre_flush", 16'd2, 16'd5);
    do_load(32'h40, 32'h1234_5678, 1'b1, st);
    check("post_flush_stall", st, 32'd4);
    check_counts("flush", 16'd2, 16'd6);

    // Reset while a read miss is outstanding
    mem_hold  = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    addr      = 32'hC4;
    @(posedge clk);
    @(negedge clk);
    check("mid_miss_state",   {30'd0, dbg_state}, 32'd1);
    check("mid_miss_mem_req", {31'd0, mem_req}, 32'd1);
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_stall",   {31'd0, stall},   32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_pulse = 1'b1;
    @(posedge clk);
    #1;
    mem_pulse = 1'b0;
    mem_hold  = 1'b0;
    @(negedge clk);
    check("late_ready_state", {30'd0, dbg_state}, 32'd0);
    check_counts("late_ready", 16'd0, 16'd0);
    @(posedge clk);
    #1;
    do_load(32'hC4, 32'h5555_AAAA, 1'b0, st);
    check("after_rst_miss_stall", st, 32'd4);
    check_counts("after_rst", 16'd0, 16'd1);

    // Hit counter saturation
    mon_en    = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    addr      = 32'hC4;
    repeat (65534) @(posedge clk);
    #1;
    req_valid = 1'b0;
    mon_en    = 1'b1;
    @(negedge clk);
    check("sat_preload", {16'd0, hit_count}, 32'h0000_FFFE);
    @(posedge clk);
    #1;
    do_load(32'hC4, 32'h5555_AAAA, 1'b0, st);
    check("sat_hit1_stall", st, 32'd0);
    check("sat_first", {16'd0, hit_count}, 32'h0000_FFFF);
    do_load(32'hC4, 32'h5555_AAAA, 1'b0, st);
    do_load(32'hC4, 32'h5555_AAAA, 1'b0, st);
    check("sat_hold", {16'd0, hit_count}, 32'h0000_FFFF);
    check("sat_misses", {16'd0, miss_count}, 32'd1);

    repeat (2) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: `clk` (1-bit input, rising edge) and `rst` (1-bit input).
REQ-002 The module SHALL have the following CPU-side ports:
- `req_valid`: input, 1 bit. Load/store request from the execute stage.
- `req_we`: input, 1 bit. 1 = store, 0 = load.
- `addr`: input, 32 bits. Byte address; `addr[1:0]` is ignored, accesses are word-aligned.
- `wdata`: input, 32 bits. Store data.
- `flush`: input, 1 bit. Invalidate all lines.
- `rdata`: output, 32 bits. Load result.
- `stall`: output, 1 bit. When 1, the CPU holds PC and the request stable.
REQ-003 The module SHALL have the following memory-side ports:
- `mem_req`: output, 1 bit.
- `mem_we`: output, 1 bit.
- `mem_addr`: output, 32 bits. Word address with bits [1:0] = 0.
- `mem_wdata`: output, 32 bits.
- `mem_ready`: input, 1 bit. One-cycle completion pulse.
- `mem_rdata`: input, 32 bits. Valid when `mem_ready` = 1.
REQ-004 The module SHALL have the following statistics outputs:
- `hit_count`: output, 16 bits.
- `miss_count`: output, 16 bits.

Function
REQ-005 Organisation SHALL be direct-mapped, 8 lines × 1 word. Index = `addr[4:2]`; tag = `addr[31:5]` (27 bits); one valid bit per line.
REQ-006 The FSM SHALL have the states IDLE, RD_MISS, WR_THRU and RESP.
REQ-007 A hit SHALL be defined as `valid[index]` = 1 and `tag[index]` = `addr[31:5]`.
REQ-008 In IDLE, a load hit (`req_valid` = 1, `req_we` = 0, hit) SHALL be served combinationally:
- `rdata` = line data, `stall` = 0, state stays IDLE.
- `hit_count` increments on that edge.
REQ-009 In IDLE, a load miss SHALL:
- assert `stall` = 1 in the same cycle;
- latch `{addr[31:2], 2'b00}` into `mem_addr`;
- increment `miss_count`;
- move to RD_MISS.
REQ-010 In RD_MISS, the module SHALL drive `mem_req` = 1, `mem_we` = 0 and `stall` = 1.
- On `mem_ready` = 1: write `mem_rdata` into the line, set its tag, set its valid bit, latch the word for `rdata`, and go to RESP.
REQ-011 In IDLE, a store (`req_valid` = 1, `req_we` = 1) SHALL:
- assert `stall` = 1 in the same cycle;
- latch the address and `wdata`;
- go to WR_THRU;
- leave both counters unchanged.
REQ-012 In WR_THRU, the module SHALL drive `mem_req` = 1, `mem_we` = 1, `mem_wdata` = latched data and `stall` = 1.
- On `mem_ready` = 1: if the line is valid with a matching tag, update its data; otherwise leave the cache unchanged (no write-allocate). Then go to RESP.
REQ-013 RESP SHALL last exactly one cycle:
- `stall` = 0; `rdata` = latched fill word for loads, don't-care for stores;
- the CPU request retires on this edge;
- the next state is IDLE, and no new request is accepted in RESP.
REQ-014 `mem_req` SHALL stay asserted with stable `mem_addr`, `mem_we` and `mem_wdata` until `mem_ready` is seen; there is no timeout.
REQ-015 In RD_MISS or WR_THRU, `mem_ready` = 0 SHALL hold the state indefinitely.
REQ-016 Outside RD_MISS and WR_THRU, `mem_req` SHALL be 0, and any `mem_ready` SHALL be ignored.
REQ-017 `flush` = 1 in IDLE SHALL clear all 8 valid bits on the next edge.
- Flush takes priority over a simultaneous request: `stall` = 1 that cycle, and the request is evaluated the following cycle against the cleared cache.
REQ-018 `flush` asserted in RD_MISS, WR_THRU or RESP SHALL be ignored; the CPU holds `flush` until IDLE.
REQ-019 `req_valid` = 0 in IDLE SHALL give `stall` = 0; `rdata` is don't-care.
REQ-020 `hit_count` and `miss_count` SHALL saturate at 16'hFFFF with no wrap.

Reset
REQ-021 `rst` = 1 SHALL act immediately, without a clock edge:
- state = IDLE, all valid bits = 0, `hit_count` = `miss_count` = 0;
- `mem_req` = 0, `mem_we` = 0, `stall` = 0 (with `req_valid` = 0).
REQ-022 Tag and data arrays SHALL NOT be reset.
REQ-023 Reset during RD_MISS or WR_THRU SHALL abandon the transaction.
- No line is filled; `mem_ready` arriving after reset is ignored.

Verification
REQ-024 Cold load: after reset, load `addr` = 0x0000_0040 with memory returning 0xDEAD_BEEF after 3 cycles.
- `stall` = 1 for 4 cycles, then RESP with `rdata` = 0xDEADBEEF.
- `miss_count` = 1.
- A repeat load of 0x40 hits with `stall` = 0, `rdata` = 0xDEADBEEF, `hit_count` = 1.
REQ-025 Conflict eviction: load 0x40, then load 0x60 (same index 0, different tag), then load 0x40 again.
- All three are misses; `miss_count` = 3; line 0 ends holding the data for 0x40.
REQ-026 Write-through, hit and no-allocate:
- Store 0x1234_5678 to cached 0x40: `mem_we` = 1 with `mem_addr` = 0x40; the following load hits and returns 0x12345678.
- Store to uncached 0x80: the following load of 0x80 misses.
REQ-027 Flush: load 0x40 so the line is valid, then assert `flush` together with a load of 0x40.
- `stall` = 1 for the flush cycle; the next-cycle load misses; `miss_count` increments.
REQ-028 Reset mid-miss: assert `rst` while in RD_MISS.
- `mem_req` drops to 0 in the same cycle.
- A later `mem_ready` pulse changes nothing; a load of the same address misses.
REQ-029 Saturation: preload `hit_count` = 0xFFFE, then issue 3 load hits.
- `hit_count` = 0xFFFF and holds.
